pipe_stage_skid: RTL and testbench

//  Parametrised valid/ready pipeline stage register for the CPU pipeline (IF/ID, ID/EX, ...).

---
 rtl/pipe_stage_skid.sv | 121 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer,
// flush-to-bubble and a saturating stall counter. Empty slots present all-zero payload.
module pipe_stage_skid #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] main_addr_q, main_addr_d, skid_addr_q, skid_addr_d;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              rdy_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept, drain;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign out_addr_o  = main_addr_q;
  assign out_data_o  = main_data_q;
  assign stall_cnt_o = cnt_q;

  // With the skid buffer, ready comes straight from a flop so out_ready_i never
  // reaches in_ready_o combinationally; without it, ready looks through to downstream.
  assign in_ready_o = (SKID != 0) ? rdy_q : (!out_valid_o || out_ready_i);

  assign accept = in_valid_i && in_ready_o;
  assign drain  = out_valid_o && out_ready_i;

  always_comb begin
    state_d     = state_q;
    main_addr_d = main_addr_q;
    main_data_d = main_data_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d     = ST_ONE;
          main_addr_d = in_addr_i;
          main_data_d = in_data_i;
        end
      end
      ST_ONE: begin
        if (accept && drain) begin
          main_addr_d = in_addr_i;
          main_data_d = in_data_i;
        end else if (accept) begin
          state_d     = ST_TWO;
          skid_addr_d = in_addr_i;
          skid_data_d = in_data_i;
        end else if (drain) begin
          state_d     = ST_EMPTY;
          main_addr_d = '0;
          main_data_d = '0;
        end
      end
      ST_TWO: begin
        if (drain) begin
          state_d     = ST_ONE;
          main_addr_d = skid_addr_q;
          main_data_d = skid_data_q;
          skid_addr_d = '0;
          skid_data_d = '0;
        end
      end
      default: begin
        state_d     = ST_EMPTY;
        main_addr_d = '0;
        main_data_d = '0;
        skid_addr_d = '0;
        skid_data_d = '0;
      end
    endcase
    if (flush_i) begin
      state_d     = ST_EMPTY;
      main_addr_d = '0;
      main_data_d = '0;
      skid_addr_d = '0;
      skid_data_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      main_addr_q <= '0;
      main_data_q <= '0;
      skid_addr_q <= '0;
      skid_data_q <= '0;
      rdy_q       <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_addr_q <= main_addr_d;
      main_data_q <= main_data_d;
      skid_addr_q <= skid_addr_d;
      skid_data_q <= skid_data_d;
      rdy_q       <= (state_d != ST_TWO);
      if (out_valid_o && !out_ready_i && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Randomized scoreboard bench for pipe_stage_skid: a skid instance and a
// no-skid/4-bit-counter instance share stimulus, each checked against a queue model.
module tb_pipe_stage_skid;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          rdy0, ov0, rdy1, ov1;
  logic [AW-1:0] oa0, oa1;
  logic [DW-1:0] od0, od1;
  logic [15:0]   cnt0;
  logic [3:0]    cnt1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.ADDR_W(AW), .DATA_W(DW), .SKID(1), .CNT_W(16)) dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy0),
    .in_addr_i(in_addr), .in_data_i(in_data), .out_valid_o(ov0), .out_ready_i(out_ready),
    .out_addr_o(oa0), .out_data_o(od0), .stall_cnt_o(cnt0));

  pipe_stage_skid #(.ADDR_W(AW), .DATA_W(DW), .SKID(0), .CNT_W(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(rdy1),
    .in_addr_i(in_addr), .in_data_i(in_data), .out_valid_o(ov1), .out_ready_i(out_ready),
    .out_addr_o(oa1), .out_data_o(od1), .stall_cnt_o(cnt1));

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  // Expected contents of each stage, oldest first; capacity 2 (skid) or 1 (no skid)
  ent_t q0[$];
  ent_t q1[$];
  int   c0, c1;
  bit   armed = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: entries accepted under the handshake rules are queued, drains pop
  always @(posedge clk) begin : model
    bit acc0, acc1, dr0, dr1;
    if (rst) begin
      q0.delete();
      q1.delete();
      c0 = 0;
      c1 = 0;
      armed = 1'b1;
    end else begin
      if (q0.size() != 0 && !out_ready && c0 < 65535) c0++;
      if (q1.size() != 0 && !out_ready && c1 < 15) c1++;
      if (flush) begin
        q0.delete();
        q1.delete();
      end else begin
        acc0 = in_valid && (q0.size() < 2);
        dr0  = (q0.size() != 0) && out_ready;
        acc1 = in_valid && (q1.size() == 0 || out_ready);
        dr1  = (q1.size() != 0) && out_ready;
        if (dr0) void'(q0.pop_front());
        if (acc0) q0.push_back({in_addr, in_data});
        if (dr1) void'(q1.pop_front());
        if (acc1) q1.push_back({in_addr, in_data});
      end
    end
  end

  // Monitor: away from the active edge, compare presented outputs with the queue heads
  always @(negedge clk) begin : monitor
    if (armed) begin
      chk("ready0", {63'd0, rdy0}, {63'd0, q0.size() < 2});
      chk("valid0", {63'd0, ov0}, {63'd0, q0.size() != 0});
      chk("cnt0", {48'd0, cnt0}, 64'(c0));
      if (ov0 && q0.size() != 0) begin
        chk("addr0", {32'd0, oa0}, {32'd0, q0[0].a});
        chk("data0", {32'd0, od0}, {32'd0, q0[0].d});
      end else if (!ov0) begin
        chk("bubble0", {oa0, od0}, 64'd0);
      end
      chk("ready1", {63'd0, rdy1}, {63'd0, (q1.size() == 0) || out_ready});
      chk("valid1", {63'd0, ov1}, {63'd0, q1.size() != 0});
      chk("cnt1", {60'd0, cnt1}, 64'(c1));
      if (ov1 && q1.size() != 0) begin
        chk("addr1", {32'd0, oa1}, {32'd0, q1[0].a});
        chk("data1", {32'd0, od1}, {32'd0, q1[0].d});
      end else if (!ov1) begin
        chk("bubble1", {oa1, od1}, 64'd0);
      end
    end
  end

  task automatic drive(input bit v, input logic [AW-1:0] a, input bit r, input bit f, input bit rs);
    in_valid  = v;
    in_addr   = a;
    in_data   = $urandom;
    out_ready = r;
    flush     = f;
    rst       = rs;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_addr = '0; in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // streaming at full rate
    for (int i = 0; i < 12; i++) drive(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0);
    // back-pressure while feeding three entries, then release
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    // fill both entries then flush with valid input present
    drive(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h204, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h208, 1'b1, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    // long stall drives the 4-bit counter into saturation
    drive(1'b1, 32'h300, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("sat1", {60'd0, cnt1}, 64'd15);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    // reset together with flush while entries are held
    drive(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h404, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h408, 1'b0, 1'b1, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 600; i++)
      drive(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
            ($urandom % 25) == 0, ($urandom % 150) == 0);
    for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
